square_rebuild: RTL
===================

Name: square_rebuild

Overview:
- Inverse of the calculator's restoring square-root unit: rebuilds the radicand from a root/remainder pair, Result = Root*Root + Rem.
- Sequential shift-and-add multiplier, one multiplier bit per clock, with a Start/Done handshake matching the sqrt unit's.
- Sits beside the sqrt datapath for round-trip self-check and for the calculator's x^2 key (Rem = 0).

Parameters:
- WIDTH, 8, root width in bits. Rem is WIDTH+1 bits and Result is 2*WIDTH bits.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset. Clears all state immediately.
- Start  input  1  request. Sampled only in IDLE.
- Root  input  WIDTH  root operand. Captured on the accepting edge.
- Rem  input  WIDTH+1  remainder operand. Captured on the accepting edge.
- Result  output  2*WIDTH  Root*Root + Rem, modulo 2^(2*WIDTH).
- Done  output  1  one-cycle completion pulse.
- Busy  output  1  high while a computation is in progress.
- Err  output  1  high when captured Rem > 2*Root, i.e. not a legal sqrt remainder.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; Result=0; Done=0; Busy=0; Err=0; all internal registers cleared.
- States: IDLE, CALC, FIN.
- IDLE, Start=1 at edge E0:
  - acc <= Rem zero-extended to 2*WIDTH.
  - mcand <= Root zero-extended to 2*WIDTH.
  - mplier <= Root.
  - cnt <= WIDTH.
  - Err <= (Rem > 2*Root), compared at WIDTH+2 bits.
  - Busy <= 1. State -> CALC.
- IDLE, Start=0: hold all outputs.
- CALC, each edge:
  - if mplier[0], acc <= acc + mcand (truncated to 2*WIDTH).
  - mcand <= mcand << 1; mplier <= mplier >> 1; cnt <= cnt - 1.
  - On the edge where cnt==1, this is the last iteration. On that same edge: Result <= final acc value, Done <= 1, Busy <= 0, state -> FIN.
- FIN, next edge: Done <= 0, state -> IDLE.
- Latency: Done is high during the cycle after edge E(WIDTH), which is exactly WIDTH edges after the accepting edge. Done is high for exactly one cycle.
- Throughput: a new Start is accepted no earlier than the edge after FIN, i.e. one request per WIDTH+2 cycles.
- Result and Err hold their values until the completion of the next computation. Result does not change during CALC; the accumulator is internal.
- Start asserted in CALC or FIN is ignored; it is not queued. Operand changes after E0 have no effect.
- Arithmetic:
  - For legal inputs, Rem <= 2*Root, so Result <= (Root+1)^2 - 1 < 2^(2*WIDTH) and no overflow occurs.
  - For illegal Rem, the sum wraps modulo 2^(2*WIDTH) and Err=1. The computation still completes normally.
- Root=0: all iterations add nothing. Result=Rem (truncated), still WIDTH cycles of latency.
- Reset mid-operation (CALC or FIN): immediate return to IDLE with all outputs 0. No Done pulse is emitted.
- Start held high continuously: the unit restarts in the cycle after FIN, giving back-to-back operations with one Done pulse each.

Test Plan:
- Reset, then Root=0, Rem=0, Start one cycle -> Busy high for 8 cycles; Done pulses exactly 8 edges after the accepting edge; Result=0, Err=0.
- Root=15, Rem=0 -> Result=225, Err=0. Then Root=15, Rem=30 -> Result=255, Err=0.
- Root=255, Rem=510 (max legal) -> Result=65535, Err=0. Root=15, Rem=31 -> Result=256, Err=1.
- Pulse Start again 3 cycles into a computation with different operands -> ignored. Only one Done pulse, carrying the first computation's Result; Result unchanged during CALC.
- Assert reset 4 cycles into CALC -> Result, Done, Busy and Err all 0 immediately; no Done pulse follows. A fresh Start after reset computes correctly.
- Round-trip: for all A in 0..255, run the sqrt unit and feed its root/remainder here (Rem = A - root^2) -> Result==A and Err=0 for every A.

Source files
------------

// File: rtl/square_rebuild.sv
// square_rebuild: rebuilds Result = Root*Root + Rem with a shift-and-add multiplier, one bit per clock
// Ports: clk, reset (async, active-high); Start/Root/Rem request and operands;
//        Result (2*WIDTH), Done (one-cycle pulse), Busy (computing), Err (Rem > 2*Root)
module square_rebuild #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               Start,
    input  logic [WIDTH-1:0]   Root,
    input  logic [WIDTH:0]     Rem,
    output logic [2*WIDTH-1:0] Result,
    output logic               Done,
    output logic               Busy,
    output logic               Err
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
    state_t state, state_nx;
    logic [2*WIDTH-1:0] acc, mcand, acc_sum;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               last;
    assign last    = cnt == CW'(1);
    assign acc_sum = mplier[0] ? acc + mcand : acc;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end
    always_comb begin
        state_nx = (state == IDLE) ? (Start ? CALC : IDLE) :
                   (state == CALC) ? (last ? FIN : CALC) : IDLE;
    end
    always_comb begin
        Busy = state == CALC;
        Done = state == FIN;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            Result <= '0;
            Err    <= 1'b0;
        end else if (state == IDLE && Start) begin
            acc    <= (2*WIDTH)'(Rem);
            mcand  <= (2*WIDTH)'(Root);
            mplier <= Root;
            cnt    <= CW'(WIDTH);
            Err    <= (WIDTH+2)'(Rem) > (WIDTH+2)'({Root, 1'b0});
        end else if (state == CALC) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
            if (last) Result <= acc_sum;
        end
    end
endmodule
